// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated N-to-1 channel multiplexer.
package arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator: round-robin with a rotating priority pointer, or fixed lowest-index priority.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = ARB_RR
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic          found;

    // Search starts at the pointer (round-robin) or at channel 0 (fixed), wrapping past N-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (MODE == ARB_FIXED) ? i : int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready arbiter feeding a single registered output slot with 1-cycle latency.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int MODE  = ARB_RR
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N*WIDTH-1:0]   I,
    input  logic [N-1:0]         V,
    output logic [N-1:0]         R,
    output logic [WIDTH-1:0]     O,
    output logic                 OV,
    input  logic                 OR,
    output logic [$clog2(N)-1:0] S
);

    localparam int SW = $clog2(N);

    logic             slot_free;
    logic             advance;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] mux_data;

    // The slot can be refilled in the same cycle its current word leaves, so no bubble.
    assign slot_free = !OV || OR;
    assign advance   = RESETN && slot_free && (|V);
    assign R         = advance ? grant : '0;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .clk       (CLK),
        .resetn    (RESETN),
        .req       (V),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        mux_data = I[int'(grant_idx)*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            O  <= '0;
            S  <= '0;
            OV <= 1'b0;
        end else if (advance) begin
            O  <= mux_data;
            S  <= grant_idx;
            OV <= 1'b1;
        end else if (slot_free) begin
            OV <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench driving a round-robin and a fixed-priority arb_mux with shared stimulus.
module tb_arb_mux;
    import arb_pkg::*;

    typedef struct {
        logic [7:0] d;
        int         s;
    } item_t;

    logic        clk;
    logic        rstn;
    logic [63:0] din;
    logic [7:0]  vin;
    logic        oready;

    logic [7:0]  r_a  [2];
    logic [7:0]  o_a  [2];
    logic        ov_a [2];
    logic [2:0]  s_a  [2];

    int vectors;
    int miscompares;

    logic       mov [2];
    logic [7:0] mo  [2];
    int         ms  [2];
    int         ptr [2];
    item_t      q0[$];
    item_t      q1[$];

    arb_mux #(.WIDTH(8), .N(8), .MODE(ARB_RR)) dut_rr (
        .CLK(clk), .RESETN(rstn), .I(din), .V(vin), .R(r_a[0]),
        .O(o_a[0]), .OV(ov_a[0]), .OR(oready), .S(s_a[0])
    );

    arb_mux #(.WIDTH(8), .N(8), .MODE(ARB_FIXED)) dut_fx (
        .CLK(clk), .RESETN(rstn), .I(din), .V(vin), .R(r_a[1]),
        .O(o_a[1]), .OV(ov_a[1]), .OR(oready), .S(s_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, m, $time, act, exp);
        end
    endtask

    // Reference rule: first requesting channel scanning from the priority start, wrapping.
    function automatic int model_grant(input int mode, input int p, input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (mode == ARB_FIXED) ? i : (p + i) % 8;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic rn, input logic [7:0] v, input logic [63:0] d, input logic orr);
        rstn   = rn;
        vin    = v;
        din    = d;
        oready = orr;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            int         g;
            logic       free;
            logic [7:0] exp_r;
            item_t      it;
            g     = model_grant(m, ptr[m], v);
            free  = !mov[m] || orr;
            exp_r = (rn && free && g >= 0) ? 8'(1 << g) : 8'h00;
            chk("ready", m, 32'(r_a[m]), 32'(exp_r));
            chk("out_valid", m, 32'(ov_a[m]), 32'(mov[m]));
            chk("out_data", m, 32'(o_a[m]), 32'(mo[m]));
            chk("out_sel", m, 32'(s_a[m]), 32'(ms[m]));
            if (!rn) begin
                mov[m] = 1'b0; mo[m] = 8'h00; ms[m] = 0; ptr[m] = 0;
                if (m == 0) q0.delete(); else q1.delete();
            end else if (free) begin
                if (g >= 0) begin
                    it.d = d[g*8 +: 8];
                    it.s = g;
                    if (m == 0) q0.push_back(it); else q1.push_back(it);
                    mov[m] = 1'b1; mo[m] = it.d; ms[m] = g; ptr[m] = (g + 1) % 8;
                end else begin
                    mov[m] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && ov_a[0] && oready) begin
                if (q0.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sb_underflow dut0 at %0t: got word %0h expected none", $time, o_a[0]);
                end else begin
                    item_t it;
                    it = q0.pop_front();
                    chk("sb_data", 0, 32'(o_a[0]), 32'(it.d));
                    chk("sb_sel", 0, 32'(s_a[0]), 32'(it.s));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && ov_a[1] && oready) begin
                if (q1.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sb_underflow dut1 at %0t: got word %0h expected none", $time, o_a[1]);
                end else begin
                    item_t it;
                    it = q1.pop_front();
                    chk("sb_data", 1, 32'(o_a[1]), 32'(it.d));
                    chk("sb_sel", 1, 32'(s_a[1]), 32'(it.s));
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        vectors     = 0;
        miscompares = 0;
        for (int m = 0; m < 2; m++) begin
            mov[m] = 1'b0; mo[m] = 8'h00; ms[m] = 0; ptr[m] = 0;
        end
        rstn = 1'b0; vin = 8'h00; din = 64'h0; oready = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then a single request on channel 0.
        step(1'b0, 8'h00, 64'h0, 1'b1);
        chk("rst_ov", 0, 32'(ov_a[0]), 32'h0);
        d = rnd64(); d[7:0] = 8'hA5;
        step(1'b1, 8'h01, d, 1'b1);
        chk("single_o", 0, 32'(o_a[0]), 32'hA5);
        chk("single_ov", 0, 32'(ov_a[0]), 32'h1);
        chk("single_s", 0, 32'(s_a[0]), 32'h0);

        // All channels requesting: round-robin rotates, fixed stays at 0.
        step(1'b0, 8'h00, 64'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'hFF, rnd64(), 1'b1);
            chk("rr_seq", 0, 32'(s_a[0]), 32'(i % 8));
            chk("fixed_seq", 1, 32'(s_a[1]), 32'h0);
        end
        step(1'b1, 8'hFE, rnd64(), 1'b1);
        chk("fixed_drop0", 1, 32'(s_a[1]), 32'h1);

        // Load channel 3, stall five cycles, then release.
        step(1'b0, 8'h00, 64'h0, 1'b1);
        d = rnd64(); d[31:24] = 8'h3C;
        step(1'b1, 8'h08, d, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hFF, rnd64(), 1'b0);
            chk("stall_o", 0, 32'(o_a[0]), 32'h3C);
            chk("stall_ov", 0, 32'(ov_a[0]), 32'h1);
            chk("stall_r", 0, 32'(r_a[0]), 32'h0);
        end
        step(1'b1, 8'hFF, rnd64(), 1'b1);
        chk("after_stall_s", 0, 32'(s_a[0]), 32'h4);

        // Reset while a word is held under back-pressure.
        step(1'b1, 8'hFF, rnd64(), 1'b0);
        step(1'b0, 8'hFF, rnd64(), 1'b0);
        chk("midrst_ov", 0, 32'(ov_a[0]), 32'h0);
        chk("midrst_o", 0, 32'(o_a[0]), 32'h0);
        chk("midrst_s", 0, 32'(s_a[0]), 32'h0);
        step(1'b1, 8'h80, rnd64(), 1'b1);
        chk("post_rst_s", 0, 32'(s_a[0]), 32'h7);
        step(1'b1, 8'hFF, rnd64(), 1'b1);
        chk("wrap_s", 0, 32'(s_a[0]), 32'h0);

        // Random traffic with occasional back-pressure and rare resets.
        for (int i = 0; i < 10000; i++) begin
            logic rn;
            logic [7:0] v;
            rn = ($urandom_range(0, 499) != 0);
            v  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(rn, v, rnd64(), ($urandom_range(0, 3) != 0));
        end

        step(1'b1, 8'h00, 64'h0, 1'b0);
        chk("sb_residue", 0, 32'(q0.size()), 32'(mov[0] ? 1 : 0));
        chk("sb_residue", 1, 32'(q1.size()), 32'(mov[1] ? 1 : 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
